counter_32_seq: RTL and testbench
=================================

# counter_32_seq

Command sequencer for the 32-bit up/down loadable counter. It accepts one command at a time over a valid/ready interface and drives the counter's `load`, `mode` and `data` inputs to perform that command. Supported commands are load, count up N steps, count down N steps, and hold N cycles. Outside commands, it keeps the counter frozen by reloading its current value. It reports completion, wrap-around and abort status per command.

## Interface
- `WIDTH`, 32: counter and argument width.
- `clk` input 1: clock; all registers rise-edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command; high only in IDLE.
- `cmd_op` input 2: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_arg` input WIDTH: LOAD value, or step/cycle count N for UP/DOWN/HOLD.
- `cmd_abort` input 1: terminate the current command.
- `cnt_q` input WIDTH: counter `data_out`.
- `cnt_load` output 1: to counter `load`.
- `cnt_mode` output 1: to counter `mode`; 1 = up.
- `cnt_data` output WIDTH: to counter `data`.
- `done` output 1: one-cycle pulse when a command ends.
- `done_wrap` output 1: valid with `done`; at least one executed step wrapped.
- `done_abort` output 1: valid with `done`; the command was aborted.

## Operation
- States: IDLE, LOAD, RUN.
- Registers:
  - `op_q`: latched op.
  - `arg_q`: latched argument.
  - `rem_q`: WIDTH-bit remaining count.
  - `wrap_q`: sticky wrap flag.
  - Registered `done`, `done_wrap`, `done_abort`.
- Handshake: a command is accepted at a rising edge where `cmd_valid` and `cmd_ready` are both 1. `cmd_op` and `cmd_arg` are sampled at that edge only.
- Transitions on acceptance from IDLE:
  - LOAD goes to LOAD.
  - UP/DOWN/HOLD with N≠0 goes to RUN with `rem_q`=N and `wrap_q` cleared.
  - UP/DOWN/HOLD with N=0 stays in IDLE and pulses `done` next cycle, with wrap=0 and abort=0.
- Output decode (combinational from state, `op_q`, `cnt_q` and `cmd_abort`):
  - IDLE: `cnt_load`=1, `cnt_data`=`cnt_q` (hold).
  - LOAD: `cnt_load`=1, `cnt_data`=`arg_q`.
  - RUN with UP: `cnt_load`=0, `cnt_mode`=1.
  - RUN with DOWN: `cnt_load`=0, `cnt_mode`=0.
  - RUN with HOLD: `cnt_load`=1, `cnt_data`=`cnt_q`.
  - Any LOAD or RUN cycle with `cmd_abort`=1: `cnt_load`=1, `cnt_data`=`cnt_q`, so no step and no load occur.
  - `cnt_mode`=0 whenever not in RUN-UP.
- LOAD state lasts one cycle, then returns to IDLE with `done`=1 next cycle.
- RUN state:
  - Each cycle is one step; `rem_q` decrements at each edge.
  - When `rem_q`=1 at an edge, the state goes to IDLE and `done` pulses.
  - RUN therefore lasts exactly N cycles, and the counter changes by N mod 2^32 for UP/DOWN.
- Wrap detection: `wrap_q` sets at any RUN edge that is not aborted where either:
  - UP and `cnt_q`=FFFFFFFF, or
  - DOWN and `cnt_q`=00000000.
- `done_wrap` for the final step includes that step's own wrap.
- Abort: `cmd_abort`=1 in a LOAD or RUN cycle forces IDLE at the next edge, with `done`=1, `done_abort`=1 and `done_wrap`=`wrap_q`. `cmd_abort` in IDLE is ignored.
- Arithmetic: `rem_q` counts down to 1 and never underflows. N up to FFFFFFFF is legal.

## Timing
- Reset values (while `rst` is high and immediately after release):
  - State IDLE; `rem_q`=0; `wrap_q`=0.
  - `done`=`done_wrap`=`done_abort`=0.
  - `cmd_ready`=1; `cnt_load`=1; `cnt_data`=`cnt_q`; `cnt_mode`=0.
- A command accepted at edge E0 executes its first cycle between E0 and E1.
- Counter updates:
  - LOAD: the counter holds `arg` after E1, and `done` is high for the cycle following E1.
  - UP/DOWN/HOLD N: the counter is final after edge EN, with `done` high for the cycle following EN.
  - N=0: `done` is high for the cycle following E0.
- Back-to-back commands:
  - The `done` cycle is an IDLE cycle with `cmd_ready`=1.
  - A new command is accepted at the edge ending that cycle.
  - The minimum command period is N+1 cycles.
- Reset mid-command: asserting `rst` returns to IDLE immediately and drops any pending `done`. The counter itself is reset by the same `rst`.

## Test plan
- LOAD: reset, then LOAD 0x12345678 → `cnt_q`=0x12345678 one edge after accept; `done`=1 for 1 cycle; wrap=0, abort=0; counter then holds 10+ cycles.
- UP with wrap: LOAD 0xFFFFFFFE, then UP 5 → `cnt_q` sequence FFFFFFFF, 0, 1, 2, 3; `done` and `done_wrap`=1 on the 5th edge.
- DOWN: LOAD 0x00000002, then DOWN 3 → 1, 0, FFFFFFFF; `done_wrap`=1. Then DOWN 2 from 0x10 → 0x0E, `done_wrap`=0.
- HOLD and zero-length: HOLD 4 with `cnt_q`=0x55 → value unchanged for 4 cycles, then `done`. UP 0 → `done` next cycle with `cnt_q` unchanged.
- Abort: LOAD 100, then UP 10; assert `cmd_abort` in the 4th RUN cycle → `cnt_q` stops at 103; `done`=1 and `done_abort`=1 one edge later; `cmd_ready` returns to 1.
- Reset mid-RUN: during UP 1000, assert `rst` asynchronously → `cnt_q`=0, IDLE, `cmd_ready`=1, no `done` pulse; a following LOAD 7 completes normally.

Source files
------------

// File: rtl/counter_32_seq_if.sv
// Command/status channel between a command source and the counter sequencer.
// The master issues commands and sees completion status; the sequencer is the slave.
interface counter_32_seq_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             cmd_abort;
    logic             done;
    logic             done_wrap;
    logic             done_abort;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_abort,
        input  cmd_ready, done, done_wrap, done_abort
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_abort,
        output cmd_ready, done, done_wrap, done_abort
    );
endinterface

// File: rtl/counter_32_seq.sv
// Command sequencer for a loadable up/down counter: runs LOAD, UP N, DOWN N and
// HOLD N commands, freezing the counter by reloading its own value otherwise.
module counter_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    counter_32_seq_if.slave  cmd,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_load,
    output logic             cnt_mode,
    output logic [WIDTH-1:0] cnt_data
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

    localparam logic [1:0]       OP_LOAD  = 2'b00;
    localparam logic [1:0]       OP_UP    = 2'b01;
    localparam logic [1:0]       OP_DOWN  = 2'b10;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             done_wrap_q, done_wrap_d;
    logic             done_abort_q, done_abort_d;
    logic             step_wrap;

    assign cmd.cmd_ready  = (state_q == ST_IDLE);
    assign cmd.done       = done_q;
    assign cmd.done_wrap  = done_wrap_q;
    assign cmd.done_abort = done_abort_q;

    assign step_wrap = ((op_q == OP_UP)   && (cnt_q == ALL_ONES)) ||
                       ((op_q == OP_DOWN) && (cnt_q == ZERO));

    // Counter drive: reloading cnt_q is how the counter is frozen, including on abort.
    always_comb begin
        cnt_load = 1'b1;
        cnt_mode = 1'b0;
        cnt_data = cnt_q;
        if (!cmd.cmd_abort) begin
            if (state_q == ST_LOAD) begin
                cnt_data = arg_q;
            end else if (state_q == ST_RUN) begin
                if (op_q == OP_UP) begin
                    cnt_load = 1'b0;
                    cnt_mode = 1'b1;
                end else if (op_q == OP_DOWN) begin
                    cnt_load = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        arg_d        = arg_q;
        rem_d        = rem_q;
        wrap_d       = wrap_q;
        done_d       = 1'b0;
        done_wrap_d  = 1'b0;
        done_abort_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d   = cmd.cmd_op;
                    arg_d  = cmd.cmd_arg;
                    wrap_d = 1'b0;
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (cmd.cmd_arg != ZERO) begin
                        state_d = ST_RUN;
                        rem_d   = cmd.cmd_arg;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (cmd.cmd_abort) begin
                    done_abort_d = 1'b1;
                    done_wrap_d  = wrap_q;
                end
            end
            ST_RUN: begin
                if (cmd.cmd_abort) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    done_abort_d = 1'b1;
                    done_wrap_d  = wrap_q;
                end else begin
                    wrap_d = wrap_q | step_wrap;
                    rem_d  = rem_q - ONE;
                    // The last step's own wrap must reach done_wrap in the same pulse.
                    if (rem_q == ONE) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        done_wrap_d = wrap_q | step_wrap;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LOAD;
            arg_q        <= '0;
            rem_q        <= '0;
            wrap_q       <= 1'b0;
            done_q       <= 1'b0;
            done_wrap_q  <= 1'b0;
            done_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arg_q        <= arg_d;
            rem_q        <= rem_d;
            wrap_q       <= wrap_d;
            done_q       <= done_d;
            done_wrap_q  <= done_wrap_d;
            done_abort_q <= done_abort_d;
        end
    end
endmodule

// File: tb/tb_counter_32_seq.sv
// Testbench for counter_32_seq: a simple counter model closes the loop, and each
// command pushes its per-edge expected results to a queue that is popped every cycle.
module tb_counter_32_seq;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef struct {
        logic [31:0] cnt;
        logic        done;
        logic        wrap;
        logic        abort;
        logic        ready;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] cnt_q;
    logic        cnt_load;
    logic        cnt_mode;
    logic [31:0] cnt_data;

    int          checks;
    int          passed;
    logic [31:0] exp_cnt;
    exp_t        exp_q[$];

    counter_32_seq_if #(.WIDTH(32)) cmd_if ();

    counter_32_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if.slave),
        .cnt_q    (cnt_q),
        .cnt_load (cnt_load),
        .cnt_mode (cnt_mode),
        .cnt_data (cnt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter being sequenced, reset by the same rst as the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_q <= '0;
        else if (cnt_load) cnt_q <= cnt_data;
        else if (cnt_mode) cnt_q <= cnt_q + 32'd1;
        else               cnt_q <= cnt_q - 32'd1;
    end

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] arg,
                           input int abort_at, input bit tail);
        exp_t        e;
        logic [31:0] v;
        logic        wrapped;
        int          len;
        int          idx;
        v       = exp_cnt;
        wrapped = 1'b0;
        e.cnt   = v;
        e.wrap  = 1'b0;
        e.abort = 1'b0;
        if (op != OP_LOAD && arg == 32'd0) begin
            e.done  = 1'b1;
            e.ready = 1'b1;
            exp_q.push_back(e);
        end else begin
            e.done  = 1'b0;
            e.ready = 1'b0;
            exp_q.push_back(e);
            len = (op == OP_LOAD) ? 1 : int'(arg);
            for (int k = 1; k <= len; k++) begin
                if (abort_at == k) begin
                    e.cnt   = v;
                    e.done  = 1'b1;
                    e.wrap  = wrapped;
                    e.abort = 1'b1;
                    e.ready = 1'b1;
                    exp_q.push_back(e);
                end else if (abort_at == 0 || k < abort_at) begin
                    case (op)
                        OP_LOAD: v = arg;
                        OP_UP: begin
                            if (v == 32'hFFFF_FFFF) wrapped = 1'b1;
                            v = v + 32'd1;
                        end
                        OP_DOWN: begin
                            if (v == 32'd0) wrapped = 1'b1;
                            v = v - 32'd1;
                        end
                        default: ;
                    endcase
                    e.cnt   = v;
                    e.done  = (k == len);
                    e.wrap  = (k == len) && wrapped;
                    e.abort = 1'b0;
                    e.ready = (k == len);
                    exp_q.push_back(e);
                end
            end
        end
        if (tail) begin
            e.cnt   = v;
            e.done  = 1'b0;
            e.wrap  = 1'b0;
            e.abort = 1'b0;
            e.ready = 1'b1;
            exp_q.push_back(e);
        end
        exp_cnt = v;

        @(negedge clk);
        checks++;
        if (cmd_if.cmd_ready !== 1'b1)
            $display("[TB] FAIL %s accept_ready: got %b want 1", tag, cmd_if.cmd_ready);
        else passed++;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            if (idx > 0) begin
                @(negedge clk);
                cmd_if.cmd_abort = (idx == abort_at);
                @(posedge clk);
                #1;
            end
            e = exp_q.pop_front();
            checks++;
            if (cnt_q !== e.cnt)
                $display("[TB] FAIL %s cnt@%0d: got %h want %h", tag, idx, cnt_q, e.cnt);
            else passed++;
            checks++;
            if (cmd_if.done !== e.done)
                $display("[TB] FAIL %s done@%0d: got %b want %b", tag, idx, cmd_if.done, e.done);
            else passed++;
            checks++;
            if (cmd_if.cmd_ready !== e.ready)
                $display("[TB] FAIL %s ready@%0d: got %b want %b", tag, idx, cmd_if.cmd_ready, e.ready);
            else passed++;
            if (e.done) begin
                checks++;
                if (cmd_if.done_wrap !== e.wrap)
                    $display("[TB] FAIL %s done_wrap@%0d: got %b want %b", tag, idx, cmd_if.done_wrap, e.wrap);
                else passed++;
                checks++;
                if (cmd_if.done_abort !== e.abort)
                    $display("[TB] FAIL %s done_abort@%0d: got %b want %b", tag, idx, cmd_if.done_abort, e.abort);
                else passed++;
            end
            idx++;
        end
        cmd_if.cmd_abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %b want 1", cmd_if.cmd_ready);
        else passed++;
        checks++;
        if ({cmd_if.done, cmd_if.done_wrap, cmd_if.done_abort} !== 3'b000)
            $display("[TB] FAIL rst_done: got %b%b%b want 000", cmd_if.done, cmd_if.done_wrap, cmd_if.done_abort);
        else passed++;
        checks++;
        if ({cnt_load, cnt_mode} !== 2'b10) $display("[TB] FAIL rst_load_mode: got %b%b want 10", cnt_load, cnt_mode);
        else passed++;
        checks++;
        if (cnt_data !== 32'd0) $display("[TB] FAIL rst_data: got %h want 0", cnt_data);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_if.cmd_ready !== 1'b1 || cmd_if.done !== 1'b0)
            $display("[TB] FAIL post_rst_idle: got ready=%b done=%b want ready=1 done=0", cmd_if.cmd_ready, cmd_if.done);
        else passed++;
        checks++;
        if (cnt_q !== 32'd0) $display("[TB] FAIL post_rst_cnt: got %h want 0", cnt_q);
        else passed++;
    endtask

    task automatic test_load();
        run_cmd("load", OP_LOAD, 32'h1234_5678, 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cnt_q !== 32'h1234_5678 || cmd_if.done !== 1'b0)
                $display("[TB] FAIL load_hold%0d: got cnt=%h done=%b want cnt=12345678 done=0", i, cnt_q, cmd_if.done);
            else passed++;
        end
    endtask

    task automatic test_up_wrap();
        run_cmd("up_pre", OP_LOAD, 32'hFFFF_FFFE, 0, 1);
        run_cmd("up_wrap", OP_UP, 32'd5, 0, 1);
    endtask

    task automatic test_down();
        run_cmd("down_pre", OP_LOAD, 32'd2, 0, 1);
        run_cmd("down_wrap", OP_DOWN, 32'd3, 0, 1);
        run_cmd("down_pre2", OP_LOAD, 32'h10, 0, 1);
        run_cmd("down_nowrap", OP_DOWN, 32'd2, 0, 1);
    endtask

    task automatic test_hold_zero();
        run_cmd("hold_pre", OP_LOAD, 32'h55, 0, 1);
        run_cmd("hold", OP_HOLD, 32'd4, 0, 1);
        run_cmd("up_zero", OP_UP, 32'd0, 0, 1);
    endtask

    task automatic test_abort();
        run_cmd("abort_pre", OP_LOAD, 32'd100, 0, 1);
        run_cmd("abort_up", OP_UP, 32'd10, 4, 1);
        run_cmd("abort_load", OP_LOAD, 32'hAAAA_0000, 1, 1);
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_load", OP_LOAD, 32'h1000, 0, 0);
        run_cmd("b2b_up", OP_UP, 32'd3, 0, 0);
        run_cmd("b2b_zero", OP_HOLD, 32'd0, 0, 0);
        run_cmd("b2b_down", OP_DOWN, 32'd2, 0, 1);
    endtask

    task automatic test_reset_mid_run();
        run_cmd("rst_pre", OP_LOAD, 32'h200, 0, 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_UP;
        cmd_if.cmd_arg   = 32'd1000;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (cnt_q !== 32'h214) $display("[TB] FAIL mid_run_cnt: got %h want 00000214", cnt_q);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (cnt_q !== 32'd0 || cmd_if.cmd_ready !== 1'b1 || cmd_if.done !== 1'b0)
            $display("[TB] FAIL async_rst: got cnt=%h ready=%b done=%b want 0/1/0", cnt_q, cmd_if.cmd_ready, cmd_if.done);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cmd_if.done !== 1'b0 || cnt_q !== 32'd0)
                $display("[TB] FAIL after_rst%0d: got done=%b cnt=%h want 0/0", i, cmd_if.done, cnt_q);
            else passed++;
        end
        run_cmd("load7", OP_LOAD, 32'd7, 0, 1);
    endtask

    initial begin
        checks           = 0;
        passed           = 0;
        exp_cnt          = 32'd0;
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_LOAD;
        cmd_if.cmd_arg   = 32'd0;
        cmd_if.cmd_abort = 1'b0;
        test_reset();
        test_load();
        test_up_wrap();
        test_down();
        test_hold_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
